// File: rtl/window_fetch_pkg.sv
// window_fetch_pkg
//   Shared constants, FSM state encoding and the window-extent helper used by
//   the window_fetch block and its output FIFO.
//   Constants: ADDR_W, DATA_W, MEM_DEPTH, IMG_W, DIM_W, RD_LAT, FIFO_D,
//   CALC_W (wide enough for the unwrapped window-end address), FIFO_CNT_W.
package window_fetch_pkg;

    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 8;
    localparam int MEM_DEPTH  = 81920;
    localparam int IMG_W      = 320;
    localparam int DIM_W      = 9;
    localparam int RD_LAT     = 1;
    localparam int FIFO_D     = 4;
    localparam int CALC_W     = ADDR_W + DIM_W + 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_D + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Address of the bottom-right byte of the window, computed without wrap.
    // Only meaningful when w and h are both non-zero.
    function automatic logic [CALC_W-1:0] window_end(
        input logic [ADDR_W-1:0] base,
        input logic [DIM_W-1:0]  w,
        input logic [DIM_W-1:0]  h
    );
        return CALC_W'(base)
             + (CALC_W'(h) - CALC_W'(1)) * CALC_W'(IMG_W)
             + CALC_W'(w) - CALC_W'(1);
    endfunction

endpackage

// File: rtl/window_fetch_fifo.sv
// window_fifo
//   Small synchronous FIFO holding {last, data} beats returned by the RAM.
//   Read data is the head entry, presented combinationally from storage and
//   therefore stable until rd_en pops it.
//   Ports: clk, rst (sync, active-high), wr_en/wr_data (push), rd_en (pop),
//          rd_data (head entry), empty, count (occupancy).
module window_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             wr_ok_s;
    logic             rd_ok_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Qualify push/pop against the current occupancy.
    always_comb begin
        full_s  = (count_r == CNT_W'(DEPTH));
        wr_ok_s = wr_en && !full_s;
        rd_ok_s = rd_en && (count_r != {CNT_W{1'b0}});
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;

endmodule

// File: rtl/window_fetch.sv
// window_fetch
//   Reads a win_w x win_h rectangle out of the row-major image RAM through one
//   read port and streams it out byte by byte (valid/ready), row-major, with
//   out_last on the final byte. Reads are only issued while the FIFO has room
//   for everything already in flight, so RAM latency never overflows it.
//   The first address is issued in the cycle after start is accepted (the
//   range check is evaluated on the raw inputs), which gives a first byte
//   RD_LAT+2 cycles after start and 1 byte/cycle sustained.
//   Optional feature: define WIN_CHECKSUM_EN to get a 16-bit running sum of
//   transferred bytes on checksum; otherwise checksum is tied to zero.
//   Ports: clk, rst (sync, active-high), start/base_addr/win_w/win_h (job),
//          busy/done/err (status), ram_addr/ram_w_en/ram_rd_data (RAM port),
//          out_data/out_valid/out_ready/out_last (stream), checksum.
module window_fetch
    import window_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  win_w,
    input  logic [DIM_W-1:0]  win_h,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [15:0]       checksum
);

    state_e               state_r;
    logic                 zero_r;
    logic                 oob_r;
    logic [DIM_W-1:0]     w_r;
    logic [DIM_W-1:0]     h_r;
    logic [DIM_W-1:0]     col_r;
    logic [DIM_W-1:0]     row_r;
    logic [ADDR_W-1:0]    row_base_r;
    logic [ADDR_W-1:0]    ram_addr_r;
    logic                 rd_v_r;
    logic                 rd_last_r;
    logic [RD_LAT-1:0]    pipe_v_r;
    logic [RD_LAT-1:0]    pipe_last_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    logic                 zero_s;
    logic                 oob_s;
    logic [3:0]           in_flight_s;
    logic                 credit_ok_s;
    logic                 col_end_s;
    logic                 issue_last_s;
    logic [ADDR_W-1:0]    issue_addr_s;
    logic                 pop_s;
    logic                 drain_done_s;
    logic                 fifo_wr_s;
    logic [DATA_W:0]      fifo_wr_data_s;
    logic [DATA_W:0]      fifo_rd_data_s;
    logic                 fifo_empty_s;
    logic [FIFO_CNT_W-1:0] fifo_count_s;

    // Job validity, credit and next-issue decode.
    always_comb begin
        zero_s = (win_w == {DIM_W{1'b0}}) || (win_h == {DIM_W{1'b0}});
        oob_s  = window_end(base_addr, win_w, win_h) >= CALC_W'(MEM_DEPTH);

        // Outstanding reads: the one on ram_addr plus those inside the RAM.
        in_flight_s = {3'b000, rd_v_r};
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight_s = in_flight_s + {3'b000, pipe_v_r[i]};
        end
        credit_ok_s = (8'({4'b0000, in_flight_s}) + 8'(fifo_count_s)) < 8'(FIFO_D);

        col_end_s    = (col_r == w_r - DIM_W'(1));
        issue_last_s = col_end_s && (row_r == h_r - DIM_W'(1));
        issue_addr_s = row_base_r + ADDR_W'(col_r);

        pop_s        = !fifo_empty_s && out_ready;
        // Finished once nothing is in flight and the last FIFO entry leaves.
        drain_done_s = (in_flight_s == 4'd0) &&
                       (fifo_empty_s || ((fifo_count_s == FIFO_CNT_W'(1)) && pop_s));

        fifo_wr_s      = pipe_v_r[RD_LAT-1];
        fifo_wr_data_s = {pipe_last_r[RD_LAT-1], ram_rd_data};
    end

    // Job sequencing FSM with registered status and RAM address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            zero_r     <= 1'b0;
            oob_r      <= 1'b0;
            w_r        <= {DIM_W{1'b0}};
            h_r        <= {DIM_W{1'b0}};
            col_r      <= {DIM_W{1'b0}};
            row_r      <= {DIM_W{1'b0}};
            row_base_r <= {ADDR_W{1'b0}};
            ram_addr_r <= {ADDR_W{1'b0}};
            rd_v_r     <= 1'b0;
            rd_last_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy_r  <= 1'b1;
                        w_r     <= win_w;
                        h_r     <= win_h;
                        zero_r  <= zero_s;
                        oob_r   <= oob_s;
                        state_r <= ST_CHECK;
                        if (!zero_s && !oob_s) begin
                            // Top-left byte goes out immediately.
                            ram_addr_r <= base_addr;
                            rd_v_r     <= 1'b1;
                            rd_last_r  <= (win_w == DIM_W'(1)) && (win_h == DIM_W'(1));
                            if (win_w == DIM_W'(1)) begin
                                col_r      <= {DIM_W{1'b0}};
                                row_r      <= DIM_W'(1);
                                row_base_r <= base_addr + ADDR_W'(IMG_W);
                            end else begin
                                col_r      <= DIM_W'(1);
                                row_r      <= {DIM_W{1'b0}};
                                row_base_r <= base_addr;
                            end
                        end else begin
                            rd_v_r     <= 1'b0;
                            rd_last_r  <= 1'b0;
                            col_r      <= {DIM_W{1'b0}};
                            row_r      <= {DIM_W{1'b0}};
                            row_base_r <= base_addr;
                        end
                    end else begin
                        rd_v_r    <= 1'b0;
                        rd_last_r <= 1'b0;
                    end
                end
                ST_CHECK, ST_FETCH: begin
                    if ((state_r == ST_CHECK) && (zero_r || oob_r)) begin
                        rd_v_r    <= 1'b0;
                        rd_last_r <= 1'b0;
                        done_r    <= 1'b1;
                        err_r     <= oob_r && !zero_r;
                        state_r   <= ST_DONE;
                    end else if ((state_r == ST_CHECK) && rd_last_r) begin
                        // Single-byte window: already fully issued.
                        rd_v_r    <= 1'b0;
                        rd_last_r <= 1'b0;
                        state_r   <= ST_DRAIN;
                    end else if (credit_ok_s) begin
                        ram_addr_r <= issue_addr_s;
                        rd_v_r     <= 1'b1;
                        rd_last_r  <= issue_last_s;
                        if (col_end_s) begin
                            col_r      <= {DIM_W{1'b0}};
                            row_r      <= row_r + DIM_W'(1);
                            row_base_r <= row_base_r + ADDR_W'(IMG_W);
                        end else begin
                            col_r <= col_r + DIM_W'(1);
                        end
                        state_r <= issue_last_s ? ST_DRAIN : ST_FETCH;
                    end else begin
                        rd_v_r    <= 1'b0;
                        rd_last_r <= 1'b0;
                        state_r   <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    rd_v_r    <= 1'b0;
                    rd_last_r <= 1'b0;
                    if (drain_done_s) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    rd_v_r    <= 1'b0;
                    rd_last_r <= 1'b0;
                    done_r    <= 1'b0;
                    err_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    rd_v_r    <= 1'b0;
                    rd_last_r <= 1'b0;
                    done_r    <= 1'b0;
                    err_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM latency tracker: valid/last travel alongside each outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_r    <= {RD_LAT{1'b0}};
            pipe_last_r <= {RD_LAT{1'b0}};
        end else begin
            pipe_v_r[0]    <= rd_v_r;
            pipe_last_r[0] <= rd_last_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_r[i]    <= pipe_v_r[i-1];
                pipe_last_r[i] <= pipe_last_r[i-1];
            end
        end
    end

    window_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_D),
        .CNT_W (FIFO_CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr_s),
        .wr_data (fifo_wr_data_s),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

`ifdef WIN_CHECKSUM_EN
    logic [15:0] sum_r;

    // Running sum of transferred bytes, restarted by each accepted job.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 16'd0;
        end else if ((state_r == ST_IDLE) && start) begin
            sum_r <= 16'd0;
        end else if (pop_s) begin
            sum_r <= sum_r + 16'(fifo_rd_data_s[DATA_W-1:0]);
        end else begin
            sum_r <= sum_r;
        end
    end

    assign checksum = sum_r;
`else
    assign checksum = 16'd0;
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign ram_addr  = ram_addr_r;
    assign ram_w_en  = 1'b0;
    assign out_valid = !fifo_empty_s;
    assign out_data  = fifo_empty_s ? {DATA_W{1'b0}} : fifo_rd_data_s[DATA_W-1:0];
    assign out_last  = !fifo_empty_s && fifo_rd_data_s[DATA_W];

endmodule
